// File: rtl/uart_host_rx.sv
// uart_host_rx: 8N1 UART receiver that acts as the host-side byte sink.
// It decodes serial frames into a single-entry holding register with a
// valid/ready handshake, and reports frame errors and overruns.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   rx          in   serial line, idles high, asynchronous to clk
//   rx_data     out  [7:0] received byte, stable while rx_valid=1
//   rx_valid    out  holding register full
//   rx_ready    in   consumer accepts when rx_valid & rx_ready
//   frame_err   out  one-cycle pulse, stop bit sampled low
//   overrun     out  sticky, completed byte dropped (register was full)
//   overrun_clr in   clears overrun; a coincident overrun event wins
//   busy        out  receiver not in IDLE
//   parity_err  out  one-cycle pulse, parity mismatch (parity build only)
//
// Build option: define UART_HOST_RX_PARITY_EN to add a parity bit between
// the data and stop bits (PARITY_ODD selects odd parity) and the
// parity_err output.
module uart_host_rx #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
`ifdef UART_HOST_RX_PARITY_EN
    ,
    parameter int unsigned PARITY_ODD = 0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       overrun_clr,
`ifdef UART_HOST_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned TICK_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int unsigned TW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW           = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF       = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL       = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_HOST_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic [TW-1:0]   r_tick_div;
    logic [CW-1:0]   r_tick_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_tick;
    logic            w_bit_end;
    logic            w_busy;
    logic            w_shift_en;
    logic            w_stop_smp;
    logic            w_complete;
    logic            w_ferr;
    logic            w_par_bad;
`ifdef UART_HOST_RX_PARITY_EN
    logic            w_par_smp;
    logic            r_par_bad;
    logic            r_par_err;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Sample-tick divider: parked at 0 in IDLE so every frame starts phase-aligned
    assign w_tick    = (r_state != S_IDLE) && (r_tick_div == TW'(TICK_DIV - 1));
    assign w_bit_end = w_tick && (r_tick_cnt == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_div <= '0;
        end else if (r_state == S_IDLE || r_tick_div == TW'(TICK_DIV - 1)) begin
            r_tick_div <= '0;
        end else begin
            r_tick_div <= r_tick_div + TW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!r_rx_s) w_next = S_START;
            S_START:  if (w_tick && r_tick_cnt == HALF) w_next = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_HOST_RX_PARITY_EN
            S_DATA:   if (w_bit_end && r_bit_idx == 3'd7) w_next = S_PARITY;
            S_PARITY: if (w_bit_end) w_next = S_STOP;
`else
            S_DATA:   if (w_bit_end && r_bit_idx == 3'd7) w_next = S_STOP;
`endif
            S_STOP:   if (w_bit_end) w_next = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (r_rx_s) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // FSM outputs and sample strobes
    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_shift_en = 1'b0;
        w_stop_smp = 1'b0;
`ifdef UART_HOST_RX_PARITY_EN
        w_par_smp  = 1'b0;
`endif
        case (r_state)
            S_DATA:   w_shift_en = w_bit_end;
`ifdef UART_HOST_RX_PARITY_EN
            S_PARITY: w_par_smp  = w_bit_end;
`endif
            S_STOP:   w_stop_smp = w_bit_end;
            default:  ;
        endcase
    end

`ifdef UART_HOST_RX_PARITY_EN
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif
    assign w_ferr     = w_stop_smp && !r_rx_s;
    assign w_complete = w_stop_smp && r_rx_s && !w_par_bad;

    // Tick-within-bit counter and bit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_BREAK: r_tick_cnt <= '0;
                S_START: if (w_tick) r_tick_cnt <= (r_tick_cnt == HALF) ? '0 : r_tick_cnt + CW'(1);
                default: if (w_tick) r_tick_cnt <= (r_tick_cnt == FULL) ? '0 : r_tick_cnt + CW'(1);
            endcase
            if (r_state == S_START) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // Shift register (LSB first) and holding register / flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
            if (w_complete && (!r_valid || rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
            // Set has priority over clear when both happen on the same edge
            if (w_complete && r_valid && !rx_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
            r_frame_err <= w_ferr;
        end
    end

`ifdef UART_HOST_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bad <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            if (w_par_smp) begin
                r_par_bad <= ((^r_shift) ^ r_rx_s) != PARITY_ODD[0];
            end
            r_par_err <= w_stop_smp && r_par_bad;
        end
    end
    assign parity_err = r_par_err;
`endif

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = w_busy;

endmodule
